// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin mutex arbiter.
// The optional hold timeout (ARB_HOLD_TIMEOUT_EN) uses clog2 to size its counter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_MAX_HOLD = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req at or after start, wrapping.
module arb_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     start,
  output logic               found,
  output logic [IDW-1:0]     idx,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    int unsigned j;
    logic [IDW-1:0] jj;
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    j      = 0;
    jj     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = int'(start) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDW'(j);
      if (!found && req[jj]) begin
        found      = 1'b1;
        idx        = jj;
        onehot[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_rr_mutex.sv
// N-way round-robin mutex arbiter: a grant is held until its requester releases it.
// Define ARB_HOLD_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles when others wait.
module arb_rr_mutex
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned IDW      = clog2(NUM_REQ),
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id
);

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               valid_q;
  logic [IDW-1:0]     id_q;
  logic [IDW-1:0]     last_q;
  logic [IDW-1:0]     start;
  logic [NUM_REQ-1:0] cand;
  logic               pick_found;
  logic [IDW-1:0]     pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               timeout;
  logic               leave;
  logic               handover;

  // The holder is masked out so a timeout never re-picks it; on release its bit is already 0.
  assign cand  = req & ~grant_q;
  assign start = (last_q == IDW'(NUM_REQ - 1)) ? '0 : last_q + 1'b1;

  arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req    (cand),
    .start  (start),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int unsigned CW = clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_q;

  // Counter holds cycles already spent; the grant lasts exactly MAX_HOLD cycles when contended.
  assign timeout = (hold_q >= CW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (handover) begin
      hold_q <= '0;
    end else if (state_q == HELD && hold_q != CW'(MAX_HOLD)) begin
      hold_q <= hold_q + 1'b1;
    end
  end
`else
  // MAX_HOLD >= 1, so this is constant false: without the timeout a grant is held indefinitely.
  assign timeout = (MAX_HOLD == 0);
`endif

  assign leave    = (state_q == HELD) && (!req[id_q] || (timeout && pick_found));
  assign handover = pick_found && ((state_q == IDLE) || leave);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
    end else if (handover) begin
      state_q <= HELD;
      grant_q <= pick_oh;
      valid_q <= 1'b1;
      id_q    <= pick_idx;
      last_q  <= pick_idx;
    end else if (leave) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;

endmodule

// File: tb/tb_arb_rr_mutex.sv
// Self-checking bench for arb_rr_mutex (NUM_REQ=4, MAX_HOLD=4): directed plan steps then random traffic.
// Honours ARB_HOLD_TIMEOUT_EN in the reference model and adds directed timeout checks when defined.
module tb_arb_rr_mutex;

  localparam int N   = 4;
  localparam int MAX = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;

  int checks   = 0;
  int failures = 0;

  // Reference model: who holds the resource, who was granted last, cycles already held.
  int holder = -1;
  int last   = N - 1;
  int held   = 0;

  always #5 clk = ~clk;

  arb_rr_mutex #(
    .NUM_REQ  (N),
    .MAX_HOLD (MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  function automatic int next_after(input int base, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [N-1:0] rq);
    logic [N-1:0] others;
    bit timed_out;
    int nxt;
    if (r) begin
      holder = -1;
      last   = N - 1;
      held   = 0;
    end else if (holder < 0) begin
      nxt = next_after(last, rq);
      if (nxt >= 0) begin
        holder = nxt;
        last   = nxt;
        held   = 0;
      end
    end else begin
      others    = rq;
      others[holder] = 1'b0;
      timed_out = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
      timed_out = (held + 1 >= MAX) && (others != 0);
`endif
      if (!rq[holder] || timed_out) begin
        nxt    = next_after(holder, others);
        holder = nxt;
        held   = 0;
        if (nxt >= 0) last = nxt;
      end else if (held < MAX) begin
        held++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq);
    logic [N-1:0] eg;
    @(negedge clk);
    rst = r;
    req = rq;
    @(posedge clk);
    model_edge(r, rq);
    #1;
    eg = (holder < 0) ? '0 : N'(1) << holder;
    chk("grant", 32'(grant), 32'(eg));
    chk("grant_valid", 32'(grant_valid), 32'(holder >= 0));
    chk("grant_id", 32'(grant_id), (holder < 0) ? 32'd0 : 32'(holder));
    chk("onehot", 32'($countones(grant) <= 1), 32'd1);
  endtask

  initial begin
    // Reset with all requesting: nothing granted.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111);
    chk("reset_grant", 32'(grant), 32'h0);
    step(1'b0, 4'b1111);
    chk("first_grant", 32'(grant), 32'b0001);

    // Mutex hold then handover without a bubble.
    step(1'b0, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b0011);
      chk("mutex_hold", 32'(grant), 32'b0001);
    end
    step(1'b0, 4'b0010);
    chk("handover", 32'(grant), 32'b0010);

    // Rotation and wrap.
    step(1'b0, 4'b1101);
    chk("rr_2", 32'(grant), 32'b0100);
    step(1'b0, 4'b1001);
    chk("rr_3", 32'(grant), 32'b1000);
    step(1'b0, 4'b0001);
    chk("rr_wrap", 32'(grant), 32'b0001);

    // Idle path then search from last+1.
    step(1'b0, 4'b0000);
    chk("idle", 32'(grant_valid), 32'd0);
    step(1'b0, 4'b1111);
    chk("idle_resume", 32'(grant), 32'b0010);

    // Mid-grant reset.
    step(1'b0, 4'b0100);
    chk("hold_2", 32'(grant), 32'b0100);
    step(1'b1, 4'b0100);
    chk("mid_reset", 32'(grant), 32'h0);
    step(1'b0, 4'b1111);
    chk("post_reset", 32'(grant), 32'b0001);

    // Single toggling requester: re-granted after one idle cycle.
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0000);
    chk("toggle_idle", 32'(grant), 32'h0);
    step(1'b0, 4'b0001);
    chk("toggle_regrant", 32'(grant), 32'b0001);

    // Continuous contention: alternates with the timeout, otherwise held forever.
    step(1'b1, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'b0011);
`ifdef ARB_HOLD_TIMEOUT_EN
      chk("timeout_alt", 32'(grant), ((i / MAX) % 2 == 1) ? 32'b0010 : 32'b0001);
`else
      chk("no_timeout", 32'(grant), 32'b0001);
`endif
    end
    step(1'b1, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b0001);
      chk("solo_hold", 32'(grant), 32'b0001);
    end

    // Random traffic; sticky requests make long holds and releases both common.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] rq;
      rq = req;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
      end
      step(($urandom_range(0, 59) == 0), rq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_rr_mutex.md
Name: arb_rr_mutex

Overview:
- Parametrised N-way mutual-exclusion arbiter; successor to the fixed 4-input, fixed-priority arbiter.
- Round-robin fairness with lock-until-release: a granted requester keeps the grant until it drops its request.
- Registered one-hot grant plus encoded grant index for shared-resource muxing.
- Sits between requesting masters and one shared resource (bus, memory port, peripheral).

Parameters:
- NUM_REQ, 4, number of requesters (2..32).
- IDW, $clog2(NUM_REQ), width of encoded grant index.
- MAX_HOLD, 16, hold-timeout cycle limit (used only with the optional feature; >=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_REQ  request vector; bit i is requester i.
- grant  output  NUM_REQ  one-hot (or zero) registered grant.
- grant_valid  output  1  high when any grant bit is set.
- grant_id  output  IDW  index of the granted requester; 0 when grant_valid=0.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset state: grant=0, grant_valid=0, grant_id=0, state=IDLE, last pointer=NUM_REQ-1, so the first search after reset starts at index 0.
- Reset dominates all other inputs, including X/Z on req.
- State machine:
  - IDLE: if req!=0, at the next edge grant the first set bit searching from last+1, wrapping modulo NUM_REQ. Update last to that index and go to HELD. If req==0, stay in IDLE.
  - HELD: while req[grant_id]=1, hold the grant unchanged; other requests are ignored (mutex).
  - HELD, holder releases: on the edge where req[grant_id]=0, choose the next requester from grant_id+1 with wrap, in the same edge and with no idle bubble. Stay in HELD. If no other request is pending, clear the grant and go to IDLE.
- Latency: request to grant is 1 clock. Release to handover is 1 clock.
- Invariants: grant always has at most one bit set. grant_valid equals the OR of grant bits. grant_id is consistent with grant.
- Simultaneous requests: rotation order decides, never a fixed index.
- Holder drops req and re-asserts it on the next cycle: it loses priority behind all other pending requesters.
- Single requester that toggles its req: it is re-granted after one IDLE cycle.

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- With the macro defined:
  - A hold counter, width $clog2(MAX_HOLD+1), clears on each new grant and increments each HELD cycle.
  - When the counter reaches MAX_HOLD and another request is pending, the grant is revoked at that edge and passed to the next requester in rotation, even though the holder's req is still high.
  - If no other request is pending, the holder keeps the grant and the counter saturates.
  - Reset clears the counter.
- Without the macro: no counter exists and the grant is held indefinitely while req stays high.

Decomposition:
- Package arb_pkg holds:
  - state encoding constants IDLE=1'b0 and HELD=1'b1;
  - a clog2 helper function;
  - the default NUM_REQ and MAX_HOLD constants.
- Sub-module arb_rr_pick: combinational rotate-priority picker.
  - Inputs: req vector and start index.
  - Outputs: found flag, index, and one-hot result.
  - Instantiated once, with start = last+1 mod NUM_REQ.

Test Plan (NUM_REQ=4):
1. Reset: rst=1 with req=1111 for 3 clocks -> grant=0000, grant_valid=0, grant_id=0. After rst=0, one edge later -> grant=0001, id=0.
2. Mutex hold: req=0001 -> grant=0001. Then req=0011 for 5 clocks -> grant stays 0001. Then req=0010 -> next edge grant=0010, id=1, no zero cycle.
3. Round-robin: holder 1 releases with req=1101 -> grant=0100, not 0001. Holder 2 releases with req=1001 -> grant=1000. Holder 3 releases with req=0001 -> grant=0001 (wrap).
4. Idle path: holder releases with req=0000 -> grant=0000, valid=0. Then req=1111 -> grant to last+1 with wrap.
5. Mid-grant reset: grant=0100 held and rst pulses for 1 clock -> grant=0000. Then req=1111 -> grant=0001.
6. ARB_HOLD_TIMEOUT_EN, MAX_HOLD=4:
   - req=0011 held continuously -> grant=0001 for 4 clocks, then 0010 for 4 clocks, alternating.
   - req=0001 alone -> grant=0001 held indefinitely.
